// File: rtl/morse_pkg.sv
// Shared types, constants and the Morse pattern lookup for the key decoder path.
// Patterns hold the first symbol in the most significant used bit; dot = 0, dash = 1.
package morse_pkg;

    localparam logic [5:0] MORSE_BLANK = 6'd36;
    localparam logic [5:0] MORSE_ERR   = 6'd63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } morse_state_e;

    // Unused bits above len are always zero because the pattern is cleared per character.
    function automatic logic [5:0] morse_lookup(input logic [2:0] len, input logic [4:0] pat);
        logic [5:0] code_s;
        code_s = MORSE_ERR;
        case ({len, pat})
            8'b001_00000: code_s = 6'd14;
            8'b001_00001: code_s = 6'd29;
            8'b010_00000: code_s = 6'd18;
            8'b010_00001: code_s = 6'd10;
            8'b010_00010: code_s = 6'd23;
            8'b010_00011: code_s = 6'd22;
            8'b011_00000: code_s = 6'd28;
            8'b011_00001: code_s = 6'd30;
            8'b011_00010: code_s = 6'd27;
            8'b011_00011: code_s = 6'd32;
            8'b011_00100: code_s = 6'd13;
            8'b011_00101: code_s = 6'd20;
            8'b011_00110: code_s = 6'd16;
            8'b011_00111: code_s = 6'd24;
            8'b100_00000: code_s = 6'd17;
            8'b100_00001: code_s = 6'd31;
            8'b100_00010: code_s = 6'd15;
            8'b100_00100: code_s = 6'd21;
            8'b100_00110: code_s = 6'd25;
            8'b100_00111: code_s = 6'd19;
            8'b100_01000: code_s = 6'd11;
            8'b100_01001: code_s = 6'd33;
            8'b100_01010: code_s = 6'd12;
            8'b100_01011: code_s = 6'd34;
            8'b100_01100: code_s = 6'd35;
            8'b100_01101: code_s = 6'd26;
            8'b101_11111: code_s = 6'd0;
            8'b101_01111: code_s = 6'd1;
            8'b101_00111: code_s = 6'd2;
            8'b101_00011: code_s = 6'd3;
            8'b101_00001: code_s = 6'd4;
            8'b101_00000: code_s = 6'd5;
            8'b101_10000: code_s = 6'd6;
            8'b101_11000: code_s = 6'd7;
            8'b101_11100: code_s = 6'd8;
            8'b101_11110: code_s = 6'd9;
            default:      code_s = MORSE_ERR;
        endcase
        return code_s;
    endfunction

endpackage

// File: rtl/morse_key_filter.sv
// Synchronises the active-low push-button and produces the active-high filtered key.
// Debounce is built only when MORSE_DEBOUNCE_EN is defined.
module morse_key_filter
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_f
);

    logic [1:0] sync_r;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], key_n};
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

    logic            raw_s;
    logic            key_f_r;
    logic [DB_W-1:0] db_cnt_r;

    assign raw_s = ~sync_r[1];

    // Accept a new level only after it has differed from the output for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_f_r  <= 1'b0;
            db_cnt_r <= DB_ZERO;
        end else if (raw_s == key_f_r) begin
            db_cnt_r <= DB_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
            key_f_r  <= raw_s;
            db_cnt_r <= DB_ZERO;
        end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
        end
    end

    assign key_f = key_f_r;
`else
    assign key_f = ~sync_r[1];
`endif

endmodule

// File: rtl/morse_key_decoder.sv
// Times key-down/key-up intervals of a Morse key and emits a 6-bit character index.
// Define MORSE_DEBOUNCE_EN to add a debounce stage on the key input.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    output logic [5:0] morse_Code,
    output logic       code_valid,
    output logic [2:0] symbol_count,
    output logic       key_down
);

    localparam int DASH_CYCLES = 2 * UNIT_CYCLES;
    localparam int GAP_CYCLES  = 3 * UNIT_CYCLES;
    localparam int CNT_W       = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             key_f_s;
    logic             sym_s;
    morse_state_e     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       pat_r;
    logic [2:0]       len_r;
    logic             overflow_r;
    logic [5:0]       code_r;
    logic             valid_r;

    morse_key_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
        .clock (clock),
        .reset (reset),
        .key_n (key_n),
        .key_f (key_f_s)
    );

    assign sym_s = (cnt_r >= DASH_CNT);

    // Dot/dash/gap timing FSM with pattern accumulation and registered character output.
    // The counter is loaded with 1 on each transition so the cycle that triggered it is counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            pat_r      <= 5'd0;
            len_r      <= 3'd0;
            overflow_r <= 1'b0;
            code_r     <= MORSE_BLANK;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    pat_r      <= 5'd0;
                    len_r      <= 3'd0;
                    overflow_r <= 1'b0;
                    if (key_f_s) begin
                        state_r <= PRESS;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                PRESS: begin
                    if (key_f_s) begin
                        if (cnt_r < DASH_CNT) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_r <= GAP;
                        cnt_r   <= CNT_ONE;
                        if (len_r == 3'd5) begin
                            overflow_r <= 1'b1;
                        end else begin
                            pat_r <= {pat_r[3:0], sym_s};
                            len_r <= len_r + 3'd1;
                        end
                    end
                end
                GAP: begin
                    // Emit takes priority over a press landing on the final gap cycle.
                    if (cnt_r == GAP_LAST) begin
                        code_r     <= overflow_r ? MORSE_ERR : morse_lookup(len_r, pat_r);
                        valid_r    <= 1'b1;
                        pat_r      <= 5'd0;
                        len_r      <= 3'd0;
                        overflow_r <= 1'b0;
                        cnt_r      <= CNT_ZERO;
                        state_r    <= IDLE;
                    end else if (key_f_s) begin
                        state_r <= PRESS;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign morse_Code   = code_r;
    assign code_valid   = valid_r;
    assign symbol_count = len_r;
    assign key_down     = key_f_s;

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Converts a single hand-operated Morse key into a 6-bit character index: 0–9 are the digits, 10–35 are A–Z, 36 is blank and 63 is error. The index is the same encoding the Morse 7-segment display block consumes, so this block is the input end of the Morse path. It sits between a DE1-SoC push-button (`KEY[n]`) and the display/character logic. It times key-down and key-up intervals to classify dots, dashes and the end of a character.

## Interface
- `UNIT_CYCLES`, default 5_000_000: one Morse time unit in clock cycles (100 ms at 50 MHz).
- `DEBOUNCE_CYCLES`, default 500_000: required input stability (10 ms); used only with `MORSE_DEBOUNCE_EN`.
- `clock`, input, 1: system clock, the single clock domain.
- `reset`, input, 1: asynchronous, active-high reset.
- `key_n`, input, 1: raw push-button, active-low, asynchronous to `clock`.
- `morse_Code`, output, 6: last decoded index (0–35, 36 blank, 63 error); held until the next character.
- `code_valid`, output, 1: one-cycle pulse when `morse_Code` updates.
- `symbol_count`, output, 3: symbols accumulated in the current character (0–5).
- `key_down`, output, 1: filtered key state, active-high, for an LED.

## Operation
- Input path: 2-flop synchroniser on `key_n`, inverted. This gives `key_f`, optionally debounced.
- Derived constants:
  - `DASH_CYCLES = 2*UNIT_CYCLES`
  - `GAP_CYCLES = 3*UNIT_CYCLES`
  - One counter, width `$clog2(GAP_CYCLES+1)`, saturating and never wrapping.
- FSM states:
  - `IDLE`: counter cleared, pattern cleared. Moves to `PRESS` when `key_f` is 1.
  - `PRESS`: counter increments every cycle, saturating at `DASH_CYCLES`. When `key_f` goes to 0, a symbol is appended and the FSM moves to `GAP` with the counter cleared.
    - The symbol is a dash (1) if counter ≥ `DASH_CYCLES`, otherwise a dot (0).
  - `GAP`: counter increments.
    - If `key_f` returns to 1 before the counter reaches `GAP_CYCLES`, go to `PRESS` with the counter cleared.
    - If the counter reaches `GAP_CYCLES`, emit the character and go to `IDLE`.
- Pattern register, 5 bits:
  - Each new symbol is shifted into bit 0: `pat <= {pat[3:0], sym}`.
  - `len` increments up to 5.
  - A 6th symbol sets a sticky `overflow` flag and leaves `pat`/`len` unchanged.
- Emit rules:
  - `morse_Code` = 63 if `overflow` is set.
  - Otherwise `morse_Code` = lookup(`len`, `pat`).
  - Patterns with no assigned character (e.g. `----`, `..--`, `.-.-`) return 63.
- `symbol_count` = `len`, cleared on emit.
- A key press held indefinitely stays in `PRESS` and the counter saturates.

## Timing
- Reset values:
  - `morse_Code` = 6'd36
  - `code_valid` = 0
  - `symbol_count` = 0
  - `key_down` = 0
  - FSM in `IDLE`, `overflow` = 0
- Reset mid-character discards the partial pattern, with no emit.
- Input latency from `key_n` to `key_f`:
  - 2 cycles with debounce disabled.
  - 2 + `DEBOUNCE_CYCLES` cycles with debounce enabled.
- Classification is by cycles `key_f` was high:
  - `DASH_CYCLES-1` or fewer cycles: dot.
  - `DASH_CYCLES` or more cycles: dash.
- `code_valid` pulses exactly `GAP_CYCLES` cycles after the first cycle `key_f` is low following the last symbol.
- `morse_Code` changes on the same edge that `code_valid` goes high.
- A press arriving on the same cycle the gap counter reaches `GAP_CYCLES`: the emit wins, and the press starts a new character through `IDLE`→`PRESS` on the next cycle.
- Lookup is combinational from registered `pat`/`len`; `morse_Code` is registered.

## Configuration
- `MORSE_DEBOUNCE_EN` defined:
  - `key_f` updates only after the synchronised input has been stable for `DEBOUNCE_CYCLES` consecutive cycles.
  - Glitches shorter than that are ignored.
- `MORSE_DEBOUNCE_EN` undefined:
  - `key_f` is the synchroniser output directly.
  - No debounce counter is synthesised.

## Structure
- Package `morse_pkg` holds:
  - the constants `MORSE_BLANK = 36` and `MORSE_ERR = 63`;
  - the FSM state enum;
  - the lookup function `morse_lookup(len, pat)` returning 6 bits.
- Sub-module `morse_key_filter` contains the synchroniser plus the optional debounce and outputs `key_f`.

## Test plan
Benches use `UNIT_CYCLES=4` (`DASH_CYCLES=8`, `GAP_CYCLES=12`) and `DEBOUNCE_CYCLES=3`.
- Reset, then idle for 50 cycles → `morse_Code`=36, `code_valid` never asserts, `symbol_count`=0.
- Press 3 cycles, release → `code_valid` pulses 12 cycles after release seen; `morse_Code`=14 (E).
- Presses of 3, 10, 3 cycles separated by 5-cycle gaps → single emit, `morse_Code`=27 (R); `symbol_count` reads 1, 2, 3 beforehand.
- Six 3-cycle dots with 5-cycle gaps → `morse_Code`=63; pattern `----` → 63; `-----` → 0.
- Assert `reset` mid-pattern after two dashes → no `code_valid`, `morse_Code` returns to 36, and the next dot decodes as 14.
- With `MORSE_DEBOUNCE_EN`: a 2-cycle `key_n` glitch → no symbol; with the macro undefined, the same glitch → `morse_Code`=14.
